// File: rtl/mandel_pkg.sv
// Shared types and default frame geometry for the Mandelbrot batch scheduler.
package mandel_pkg;
    localparam int PIXEL_DATA_WIDTH = 10;
    localparam int ITER_WIDTH       = 8;
    localparam int SCREEN_WIDTH     = 640;
    localparam int SCREEN_HEIGHT    = 480;
    localparam int NUM_ENGINES      = 8;

    typedef logic [PIXEL_DATA_WIDTH-1:0] coord_t;
    typedef logic [ITER_WIDTH-1:0]       iter_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DRAIN
    } sched_state_e;
endpackage

// File: rtl/batch_coord_gen.sv
// Maps a batch base pixel to per-slot coordinates, slot validity, the next batch base
// and whether this batch contains the frame's final pixel. Purely combinational.
module batch_coord_gen #(
    parameter int PIXEL_DATA_WIDTH = mandel_pkg::PIXEL_DATA_WIDTH,
    parameter int SCREEN_WIDTH     = mandel_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT    = mandel_pkg::SCREEN_HEIGHT,
    parameter int NUM_ENGINES      = mandel_pkg::NUM_ENGINES
) (
    input  logic [PIXEL_DATA_WIDTH-1:0]                  base_x,
    input  logic [PIXEL_DATA_WIDTH-1:0]                  base_y,
    output logic [NUM_ENGINES-1:0][PIXEL_DATA_WIDTH-1:0] slot_x,
    output logic [NUM_ENGINES-1:0][PIXEL_DATA_WIDTH-1:0] slot_y,
    output logic [NUM_ENGINES-1:0]                       slot_valid,
    output logic [PIXEL_DATA_WIDTH-1:0]                  next_x,
    output logic [PIXEL_DATA_WIDTH-1:0]                  next_y,
    output logic                                         last_batch
);
    import mandel_pkg::*;

    localparam int PDW = PIXEL_DATA_WIDTH;
    localparam int EW  = PIXEL_DATA_WIDTH + 1;
    localparam logic [EW-1:0]  W_E = EW'(SCREEN_WIDTH);
    localparam logic [EW-1:0]  H_E = EW'(SCREEN_HEIGHT);
    localparam logic [PDW-1:0] W_C = PDW'(SCREEN_WIDTH);

    logic [NUM_ENGINES-1:0] slot_last;

    // Sums are widened by one bit so bx+i never overflows before the wrap compare.
    for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_slot
        logic [EW-1:0] sum_x;
        logic [EW-1:0] ext_y;
        logic          wrap;

        assign sum_x         = {1'b0, base_x} + EW'(i);
        assign wrap          = (sum_x >= W_E);
        assign ext_y         = {1'b0, base_y} + EW'(wrap);
        assign slot_x[i]     = base_x + PDW'(i) - (wrap ? W_C : '0);
        assign slot_y[i]     = ext_y[PDW-1:0];
        assign slot_valid[i] = (ext_y < H_E);
        assign slot_last[i]  = slot_valid[i] && (ext_y == H_E - EW'(1))
                               && (slot_x[i] == W_C - PDW'(1));
    end

    logic [EW-1:0] next_sum;
    logic          next_wrap;

    assign next_sum   = {1'b0, base_x} + EW'(NUM_ENGINES);
    assign next_wrap  = (next_sum >= W_E);
    assign next_x     = base_x + PDW'(NUM_ENGINES) - (next_wrap ? W_C : '0);
    assign next_y     = base_y + PDW'(next_wrap);
    assign last_batch = |slot_last;
endmodule

// File: rtl/mandel_batch_scheduler.sv
// Frame sequencer: launches a batch of escape-time engines on consecutive raster pixels,
// collects their iteration counts, then streams results out in raster order.
module mandel_batch_scheduler #(
    parameter int PIXEL_DATA_WIDTH = mandel_pkg::PIXEL_DATA_WIDTH,
    parameter int SCREEN_WIDTH     = mandel_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT    = mandel_pkg::SCREEN_HEIGHT,
    parameter int NUM_ENGINES      = mandel_pkg::NUM_ENGINES,
    parameter int ITER_WIDTH       = mandel_pkg::ITER_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         frame_start,
    output logic [NUM_ENGINES-1:0]                       eng_start,
    output logic [NUM_ENGINES-1:0][PIXEL_DATA_WIDTH-1:0] eng_x,
    output logic [NUM_ENGINES-1:0][PIXEL_DATA_WIDTH-1:0] eng_y,
    input  logic [NUM_ENGINES-1:0]                       eng_done,
    input  logic [NUM_ENGINES-1:0][ITER_WIDTH-1:0]       eng_iter,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [ITER_WIDTH-1:0]                        out_iter,
    output logic [PIXEL_DATA_WIDTH-1:0]                  out_x,
    output logic [PIXEL_DATA_WIDTH-1:0]                  out_y,
    output logic                                         out_sof,
    output logic                                         out_eol,
    output logic                                         busy,
    output logic                                         frame_done
);
    import mandel_pkg::*;

    localparam int PDW   = PIXEL_DATA_WIDTH;
    localparam int N     = NUM_ENGINES;
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    sched_state_e                 state_q, state_d;
    logic [PDW-1:0]               bx_q, bx_d, by_q, by_d;
    logic [PDW-1:0]               nxt_bx_q, nxt_bx_d, nxt_by_q, nxt_by_d;
    logic                         last_q, last_d;
    logic [N-1:0]                 done_mask_q, done_mask_d;
    logic [N-1:0]                 slot_valid_q, slot_valid_d;
    logic [N-1:0][ITER_WIDTH-1:0] res_q, res_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [N-1:0]                 eng_start_q, eng_start_d;
    logic [N-1:0][PDW-1:0]        eng_x_q, eng_x_d, eng_y_q, eng_y_d;
    logic                         frame_done_q, frame_done_d;
    logic                         launch;

    logic [N-1:0][PDW-1:0]        gen_x, gen_y;
    logic [N-1:0]                 gen_valid;
    logic [PDW-1:0]               gen_next_x, gen_next_y;
    logic                         gen_last;

    // Fed with the base being launched, so slot coords land in eng_x/eng_y on the LAUNCH edge.
    batch_coord_gen #(
        .PIXEL_DATA_WIDTH (PIXEL_DATA_WIDTH),
        .SCREEN_WIDTH     (SCREEN_WIDTH),
        .SCREEN_HEIGHT    (SCREEN_HEIGHT),
        .NUM_ENGINES      (NUM_ENGINES)
    ) u_coord_gen (
        .base_x     (bx_d),
        .base_y     (by_d),
        .slot_x     (gen_x),
        .slot_y     (gen_y),
        .slot_valid (gen_valid),
        .next_x     (gen_next_x),
        .next_y     (gen_next_y),
        .last_batch (gen_last)
    );

    // Valid slots are always a prefix, so the beat is last when the following slot is invalid.
    logic [N-1:0] more_valid;
    logic         beat_last;

    assign more_valid = slot_valid_q >> 1;
    assign beat_last  = !more_valid[ptr_q];

    always_comb begin
        state_d      = state_q;
        bx_d         = bx_q;
        by_d         = by_q;
        ptr_d        = ptr_q;
        frame_done_d = 1'b0;
        launch       = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = LAUNCH;
                    bx_d    = '0;
                    by_d    = '0;
                    launch  = 1'b1;
                end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (&done_mask_q) begin
                    state_d = DRAIN;
                    ptr_d   = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (beat_last) begin
                        ptr_d = '0;
                        if (last_q) begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = LAUNCH;
                            bx_d    = nxt_bx_q;
                            by_d    = nxt_by_q;
                            launch  = 1'b1;
                        end
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eng_start_d  = '0;
        eng_x_d      = eng_x_q;
        eng_y_d      = eng_y_q;
        slot_valid_d = slot_valid_q;
        done_mask_d  = done_mask_q;
        res_d        = res_q;
        last_d       = last_q;
        nxt_bx_d     = nxt_bx_q;
        nxt_by_d     = nxt_by_q;
        // Dones are accepted from the LAUNCH cycle onward; repeats and invalid slots are masked.
        for (int i = 0; i < N; i++) begin
            if ((state_q == LAUNCH || state_q == WAIT) && eng_done[i] && !done_mask_q[i]) begin
                res_d[i]       = eng_iter[i];
                done_mask_d[i] = 1'b1;
            end
        end
        if (launch) begin
            eng_start_d  = gen_valid;
            eng_x_d      = gen_x;
            eng_y_d      = gen_y;
            slot_valid_d = gen_valid;
            done_mask_d  = ~gen_valid;
            last_d       = gen_last;
            nxt_bx_d     = gen_next_x;
            nxt_by_d     = gen_next_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bx_q         <= '0;
            by_q         <= '0;
            nxt_bx_q     <= '0;
            nxt_by_q     <= '0;
            last_q       <= 1'b0;
            done_mask_q  <= '0;
            slot_valid_q <= '0;
            res_q        <= '0;
            ptr_q        <= '0;
            eng_start_q  <= '0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            nxt_bx_q     <= nxt_bx_d;
            nxt_by_q     <= nxt_by_d;
            last_q       <= last_d;
            done_mask_q  <= done_mask_d;
            slot_valid_q <= slot_valid_d;
            res_q        <= res_d;
            ptr_q        <= ptr_d;
            eng_start_q  <= eng_start_d;
            eng_x_q      <= eng_x_d;
            eng_y_q      <= eng_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = (state_q == DRAIN);
    assign out_iter   = out_valid ? res_q[ptr_q]   : '0;
    assign out_x      = out_valid ? eng_x_q[ptr_q] : '0;
    assign out_y      = out_valid ? eng_y_q[ptr_q] : '0;
    assign out_sof    = out_valid && (out_x == '0) && (out_y == '0);
    assign out_eol    = out_valid && (out_x == PDW'(SCREEN_WIDTH - 1));
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign eng_start  = eng_start_q;
    assign eng_x      = eng_x_q;
    assign eng_y      = eng_y_q;
endmodule

// File: tb/tb_mandel_batch_scheduler.sv
// Scoreboard bench for mandel_batch_scheduler on an 8x2 frame with three engines.
module tb_mandel_batch_scheduler;
    localparam int PDW  = 10;
    localparam int W    = 8;
    localparam int H    = 2;
    localparam int N    = 3;
    localparam int IW   = 8;
    localparam int NPIX = W * H;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  frame_start = 1'b0;
    logic [N-1:0]          eng_start;
    logic [N-1:0][PDW-1:0] eng_x, eng_y;
    logic [N-1:0]          eng_done = '0;
    logic [N-1:0][IW-1:0]  eng_iter = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [IW-1:0]         out_iter;
    logic [PDW-1:0]        out_x, out_y;
    logic                  out_sof, out_eol, busy, frame_done;

    always #5 clk = ~clk;

    mandel_batch_scheduler #(
        .PIXEL_DATA_WIDTH (PDW),
        .SCREEN_WIDTH     (W),
        .SCREEN_HEIGHT    (H),
        .NUM_ENGINES      (N),
        .ITER_WIDTH       (IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .eng_start   (eng_start),
        .eng_x       (eng_x),
        .eng_y       (eng_y),
        .eng_done    (eng_done),
        .eng_iter    (eng_iter),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_iter    (out_iter),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    typedef struct packed {
        logic [PDW-1:0] x;
        logic [PDW-1:0] y;
        logic [IW-1:0]  iter;
        logic           sof;
        logic           eol;
    } pix_t;

    pix_t sb[$];
    int   launch_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fd_cnt = 0;
    int   dly[N] = '{5, 5, 5};
    bit   dup_mode = 1'b0;
    int   rdy_mode = 0;

    function automatic logic [IW-1:0] f_iter(input int x, input int y);
        return IW'(x * 16 + y * 4 + 3);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Engine model: answers each start after dly[i] cycles with an iteration count derived
    // from the coordinate it was handed; optionally adds spurious repeat / invalid-slot dones.
    initial begin
        int            cnt[N];
        bit            pend[N];
        logic [IW-1:0] val[N];
        bit            dup;
        dup = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; cnt[i] = 0; val[i] = '0; end
        forever begin
            @(posedge clk); #2;
            eng_done = '0;
            if (reset) begin
                for (int i = 0; i < N; i++) pend[i] = 1'b0;
                dup = 1'b0;
            end else begin
                if (dup) begin eng_done[2] = 1'b1; eng_iter[2] = 8'hEE; dup = 1'b0; end
                for (int i = 0; i < N; i++) begin
                    if (pend[i]) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            pend[i] = 1'b0;
                            eng_done[i] = 1'b1;
                            eng_iter[i] = val[i];
                            if (dup_mode && i == 2) dup = 1'b1;
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (eng_start[i]) begin
                        pend[i] = 1'b1;
                        cnt[i]  = dly[i];
                        val[i]  = f_iter(int'(eng_x[i]), int'(eng_y[i]));
                    end
                end
                if (dup_mode && eng_start == 3'b001) begin
                    for (int i = 1; i < N; i++) begin pend[i] = 1'b1; cnt[i] = 1; val[i] = 8'hEE; end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: launches, output beats (stalled or accepted) and frame_done against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (eng_start != '0) begin
                    if (launch_q.size() == 0) fail_now("launch_unexpected");
                    else begin
                        int           p;
                        logic [N-1:0] pat;
                        p = launch_q.pop_front();
                        for (int i = 0; i < N; i++) pat[i] = (p + i) < NPIX;
                        check("launch_mask", eng_start, pat);
                        for (int i = 0; i < N; i++)
                            if (pat[i]) check("launch_xy", {eng_x[i], eng_y[i]},
                                              {PDW'((p + i) % W), PDW'((p + i) / W)});
                    end
                end
                if (out_valid) begin
                    if (sb.size() == 0) fail_now("out_unexpected");
                    else begin
                        check(out_ready ? "out_pix" : "out_stall",
                              {out_x, out_y, out_iter, out_sof, out_eol}, sb[0]);
                        if (out_ready) void'(sb.pop_front());
                    end
                end
                if (frame_done) begin
                    fd_cnt++;
                    check("fd_drained", sb.size(), 0);
                    check("fd_busy", busy, 1'b0);
                end
            end
        end
    end

    task automatic push_frame();
        pix_t e;
        for (int p = 0; p < NPIX; p++) begin
            e.x    = PDW'(p % W);
            e.y    = PDW'(p / W);
            e.iter = f_iter(p % W, p / W);
            e.sof  = (p == 0);
            e.eol  = ((p % W) == W - 1);
            sb.push_back(e);
        end
        for (int b = 0; b < NPIX; b += N) launch_q.push_back(b);
    endtask

    task automatic start_frame();
        push_frame();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        check("start_latency", eng_start, 3'b111);
        check("busy_launch", busy, 1'b1);
    endtask

    task automatic wait_frame(input int budget);
        int s;
        int n;
        s = fd_cnt;
        n = 0;
        while (fd_cnt == s && n < budget) begin @(posedge clk); n++; end
        if (fd_cnt == s) fail_now("frame_timeout");
        repeat (4) @(posedge clk);
        #1;
        check("fd_once", fd_cnt, s + 1);
        check("idle_busy", busy, 1'b0);
        check("sb_empty", sb.size(), 0);
        check("launch_empty", launch_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        sb.delete();
        launch_q.delete();
        @(posedge clk); #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_start", eng_start, '0);
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("init_busy", busy, 1'b0);
        check("init_valid", out_valid, 1'b0);
        check("init_start", eng_start, '0);
        check("init_engxy", {eng_x, eng_y}, '0);
        check("init_out", {out_iter, out_x, out_y, out_sof, out_eol, frame_done}, '0);
        reset = 1'b0;

        // Uniform engines, always-ready sink.
        start_frame();
        wait_frame(400);

        // Out-of-order dones (2, then 0 and 1 together), spurious dones, random back-pressure,
        // and a frame_start mid-frame that must be ignored.
        dly = '{4, 4, 2};
        dup_mode = 1'b1;
        rdy_mode = 1;
        start_frame();
        repeat (3) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        wait_frame(600);
        dup_mode = 1'b0;

        // Reset while the first batch is still computing.
        dly = '{5, 5, 5};
        rdy_mode = 0;
        start_frame();
        do_reset();

        // Reset while a result is stalled in DRAIN.
        rdy_mode = 2;
        start_frame();
        begin
            int n;
            n = 0;
            while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
            if (!out_valid) fail_now("drain_timeout");
        end
        do_reset();

        // Fresh frame after reset restarts at (0,0).
        rdy_mode = 1;
        start_frame();
        wait_frame(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
